sobol_gen: RTL and testbench
============================

SOBOL_GEN -- requirements
Module: sobol_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the bit width of the sequence value and the step counter.
REQ-002 SHALL have parameter LOGWIDTH, default 3, meaning the bit width of the direction-vector index (clog2 of WIDTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: advance the sequence by one step this cycle.
REQ-006 SHALL have port clr, input, 1 bit: synchronous restart of the sequence, with no effect on direction vectors.
REQ-007 SHALL have port out, output, WIDTH bits: the current Sobol value x_n, driven from a register.
REQ-008 SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking the end of the sequence period.
REQ-009 SHALL have ports dv_we (input, 1 bit, write strobe), dv_addr (input, LOGWIDTH bits, vector index) and dv_data (input, WIDTH bits, vector value), present only when SOBOL_DV_LOAD_EN is defined.

Function
REQ-010 SHALL hold a WIDTH-bit step counter cnt and a WIDTH-bit state register seq; out SHALL equal seq.
REQ-011 SHALL compute idx as the position of the least significant zero bit of cnt, combinationally and internally.
REQ-012 SHALL, on a cycle with en=1, clr=0, rst=0 and cnt not all-ones, update seq to seq XOR dv[idx] and cnt to cnt+1 at the next edge (1-cycle latency).
REQ-013 SHALL, on a cycle with en=1 and cnt all-ones, load seq=0 and cnt=0 at the next edge, and assert wrap for exactly the following cycle; the period is therefore 2^WIDTH.
REQ-014 SHALL hold seq, cnt and wrap=0 on cycles with en=0.
REQ-015 SHALL, with clr=1, load seq=0, cnt=0 and wrap=0 at the next edge, regardless of en.
REQ-016 SHALL apply priority rst > clr > en.
REQ-017 SHALL use default direction vectors dv[k] = 1 << (WIDTH-1-k) for k = 0..WIDTH-1.
REQ-018 SHALL visit every WIDTH-bit value exactly once per period, starting from 0.

Reset
REQ-019 SHALL, on rst=1 at a clock edge, set seq=0 (out=0), cnt=0 and wrap=0.
REQ-020 SHALL, on reset asserted mid-sequence, restart from x_0=0 on the first cycle after reset is released, with no wrap pulse.
REQ-021 SHALL, on reset, restore every direction vector to the REQ-017 defaults.

Configuration
REQ-022 SHALL, with SOBOL_DV_LOAD_EN defined, hold dv in a WIDTH-entry register file; dv_we=1 writes dv_data into dv[dv_addr] at the edge.
REQ-023 SHALL, when a write and an en step occur in the same cycle, compute the step with the old dv value; the written value takes effect from the next cycle.
REQ-024 SHALL, when rst=1 and dv_we=1 occur together, let reset win and ignore the write.
REQ-025 SHALL, without SOBOL_DV_LOAD_EN, omit the dv_* ports and implement dv as constants per REQ-017.

Verification
REQ-026 SHALL cover: reset, then en=1 for 6 cycles (WIDTH=8) -> out = 0x00, 0x80, 0xC0, 0x40, 0x60, 0xE0, 0xA0.
REQ-027 SHALL cover: en=1 for 256 cycles -> all 256 values appear exactly once, out returns to 0x00, and wrap pulses once in the cycle out returns to 0x00.
REQ-028 SHALL cover: en toggled 1,0,0,1 -> out advances only after en=1 cycles and holds otherwise; wrap stays 0.
REQ-029 SHALL cover: clr=1 and en=1 together after 10 steps -> out=0x00 next cycle; with the macro defined, loaded dv values are retained.
REQ-030 SHALL cover (macro defined): write dv[0]=0x01 in the same cycle as the first en -> out=0x80 first; a later step with idx=0 XORs 0x01.
REQ-031 SHALL cover: rst asserted at step 100 -> out=0x00, wrap=0, and the sequence restarts at 0x80 on the first en after reset.

Source files
------------

// File: rtl/sobol_gen.sv
// Sobol low-discrepancy sequence generator: x_{n+1} = x_n ^ dv[lsz(n)], period 2^WIDTH.
// Optional runtime-loadable direction vectors are enabled with `define SOBOL_DV_LOAD_EN.
module sobol_gen #(
  parameter int WIDTH    = 8,
  parameter int LOGWIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             wrap
`ifdef SOBOL_DV_LOAD_EN
  ,
  input  logic                dv_we,
  input  logic [LOGWIDTH-1:0] dv_addr,
  input  logic [WIDTH-1:0]    dv_data
`endif
);

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    seq_q, seq_d;
  logic                wrap_q, wrap_d;
  logic [LOGWIDTH-1:0] idx;
  logic [WIDTH-1:0]    dv [WIDTH];

  function automatic logic [WIDTH-1:0] default_dv(input int k);
    logic [WIDTH-1:0] r;
    r = '0;
    r[WIDTH-1-k] = 1'b1;
    return r;
  endfunction

`ifdef SOBOL_DV_LOAD_EN
  // Writes land at the edge, so a same-cycle step still uses the old vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < WIDTH; k++) dv[k] <= default_dv(k);
    end else if (dv_we) begin
      dv[dv_addr] <= dv_data;
    end
  end
`else
  always_comb begin
    for (int k = 0; k < WIDTH; k++) dv[k] = default_dv(k);
  end
`endif

  // Position of the least significant zero bit of the step counter.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!cnt_q[i]) idx = LOGWIDTH'(i);
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    seq_d  = seq_q;
    wrap_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
      seq_d = '0;
    end else if (en) begin
      if (&cnt_q) begin
        cnt_d  = '0;
        seq_d  = '0;
        wrap_d = 1'b1;
      end else begin
        seq_d = seq_q ^ dv[idx];
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      seq_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      seq_q  <= seq_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = seq_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_sobol_gen.sv
// Directed bench for sobol_gen (WIDTH=8): reset, stepping, hold, clear, full period, mid-run reset.
module tb_sobol_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] out;
  logic       wrap;
`ifdef SOBOL_DV_LOAD_EN
  logic       dv_we;
  logic [2:0] dv_addr;
  logic [7:0] dv_data;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       seen [256];
  int         distinct;
  int         wrap_count;

  sobol_gen #(.WIDTH(8), .LOGWIDTH(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .out     (out),
    .wrap    (wrap)
`ifdef SOBOL_DV_LOAD_EN
    ,
    .dv_we   (dv_we),
    .dv_addr (dv_addr),
    .dv_data (dv_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: x_n is the bit-reversed Gray code of n for the default vectors.
  function automatic logic [7:0] model(input int n);
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
    b = n[7:0];
    g = b ^ (b >> 1);
    for (int i = 0; i < 8; i++) r[i] = g[7-i];
    return r;
  endfunction

  task automatic cyc(input logic e, input logic c, input logic r);
    en  = e;
    clr = c;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check8(tag, out, e);
  endtask

  task automatic check_wrap(input string tag, input logic exp);
    checks++;
    assert (wrap === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, wrap, exp);
    end
  endtask

  initial begin
    en  = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
`ifdef SOBOL_DV_LOAD_EN
    dv_we   = 1'b0;
    dv_addr = '0;
    dv_data = '0;
`endif

    // Reset state
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check8("reset_out", out, 8'h00);
    check_wrap("reset_wrap", 1'b0);

    // First six steps
    exp_q = {8'h80, 8'hC0, 8'h40, 8'h60, 8'hE0, 8'hA0};
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      check_out($sformatf("step%0d", i + 1));
      check_wrap("step_wrap", 1'b0);
    end

    // en pattern 1,0,0,1
    exp_q = {8'h20, 8'h20, 8'h20, 8'h30};
    cyc(1'b1, 1'b0, 1'b0); check_out("en_1a"); check_wrap("en_wrap", 1'b0);
    cyc(1'b0, 1'b0, 1'b0); check_out("en_0a"); check_wrap("en_wrap", 1'b0);
    cyc(1'b0, 1'b0, 1'b0); check_out("en_0b"); check_wrap("en_wrap", 1'b0);
    cyc(1'b1, 1'b0, 1'b0); check_out("en_1b"); check_wrap("en_wrap", 1'b0);

    // Two more steps to reach 10, then clear with en high
    exp_q = {8'hB0, 8'hF0, 8'h00, 8'h80};
    cyc(1'b1, 1'b0, 1'b0); check_out("step9");
    cyc(1'b1, 1'b0, 1'b0); check_out("step10");
    cyc(1'b1, 1'b1, 1'b0); check_out("clr_out"); check_wrap("clr_wrap", 1'b0);
    cyc(1'b1, 1'b0, 1'b0); check_out("after_clr");

    // Full period from zero
    cyc(1'b0, 1'b1, 1'b0);
    check8("period_start", out, 8'h00);
    for (int v = 0; v < 256; v++) seen[v] = 1'b0;
    seen[0]    = 1'b1;
    distinct   = 1;
    wrap_count = 0;
    for (int n = 1; n <= 256; n++) begin
      exp_q.push_back(model(n));
      cyc(1'b1, 1'b0, 1'b0);
      check_out("period_val");
      if (wrap === 1'b1) wrap_count++;
      if (n < 256) begin
        check_wrap("period_nowrap", 1'b0);
        if (!seen[out]) distinct++;
        seen[out] = 1'b1;
      end
    end
    check8("period_return", out, 8'h00);
    check_wrap("period_wrap", 1'b1);
    checks++;
    assert (distinct == 256) else begin
      errors++;
      $error("FAIL period_distinct: observed %0d expected 256", distinct);
    end
    checks++;
    assert (wrap_count == 1) else begin
      errors++;
      $error("FAIL period_wrap_count: observed %0d expected 1", wrap_count);
    end
    cyc(1'b0, 1'b0, 1'b0);
    check_wrap("wrap_one_cycle", 1'b0);
    check8("hold_after_wrap", out, 8'h00);

    // Reset at step 100
    cyc(1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 100; n++) cyc(1'b1, 1'b0, 1'b0);
    check8("step100", out, 8'h6A);
    cyc(1'b1, 1'b1, 1'b1);
    check8("midrst_out", out, 8'h00);
    check_wrap("midrst_wrap", 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check8("restart_out", out, 8'h80);
    check_wrap("restart_wrap", 1'b0);

`ifdef SOBOL_DV_LOAD_EN
    // Vector write in the same cycle as the first step
    cyc(1'b0, 1'b1, 1'b0);
    dv_we = 1'b1; dv_addr = 3'd0; dv_data = 8'h01;
    cyc(1'b1, 1'b0, 1'b0);
    dv_we = 1'b0;
    check8("dv_first", out, 8'h80);
    cyc(1'b1, 1'b0, 1'b0);
    check8("dv_second", out, 8'hC0);
    cyc(1'b1, 1'b0, 1'b0);
    check8("dv_idx0", out, 8'hC1);
    cyc(1'b1, 1'b1, 1'b0);
    check8("dv_clr", out, 8'h00);
    cyc(1'b1, 1'b0, 1'b0);
    check8("dv_retained", out, 8'h01);
    // Reset beats a simultaneous write and restores defaults
    dv_we = 1'b1; dv_addr = 3'd1; dv_data = 8'hFF;
    cyc(1'b0, 1'b0, 1'b1);
    dv_we = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    check8("dv_rst_default0", out, 8'h80);
    cyc(1'b1, 1'b0, 1'b0);
    check8("dv_rst_default1", out, 8'hC0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
